// File: rtl/ad_ip_jesd204_tpl_up_pkg.sv
// Shared types and constants for the JESD204 TPL up-bus fan-out/fan-in fabric.
package ad_ip_jesd204_tpl_up_pkg;

   // One transaction path walks IDLE -> WAIT -> RESP -> IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } txn_state_e;

   // Up-bus data word width.
   localparam int UP_DATA_WIDTH = 32;

   // Read data handed back when no slave claims a read.
   localparam logic [UP_DATA_WIDTH-1:0] DEFAULT_TIMEOUT_RDATA = 32'hDEADDEAD;

   // Width of the wait timer: it only has to reach TIMEOUT_CYCLES-1.
   function automatic int timer_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_up_txn.sv
// One up-bus transaction path (read or write): request broadcast, ack
// collection, timeout and multi-ack detection. DATA_EN selects whether the
// data register holds captured read data (1) or the write data (0).
module ad_ip_jesd204_tpl_up_txn
   import ad_ip_jesd204_tpl_up_pkg::*;
#(
   parameter int          NUM_SLAVES     = 4,
   parameter int          ADDR_WIDTH     = 11,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA,
   parameter bit          DATA_EN        = 1'b0
) (
   input  logic                     up_clk,
   input  logic                     up_rst,
   input  logic                     m_req,
   input  logic [ADDR_WIDTH-1:0]    m_addr,
   input  logic [31:0]              m_wdata,
   output logic                     m_ack,
   output logic                     s_req,
   output logic [ADDR_WIDTH-1:0]    s_addr,
   input  logic [NUM_SLAVES-1:0]    s_ack,
   input  logic [NUM_SLAVES*32-1:0] s_rdata,
   output logic [31:0]              data,
   output logic                     timeout_evt,
   output logic                     multi_ack_evt
);

   localparam int TW = timer_width(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   txn_state_e            state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic                  s_req_q, s_req_d;
   logic                  m_ack_q, m_ack_d;

   logic [31:0]           ack_data;
   logic [6:0]            ack_cnt;
   logic                  ack_any;

   // Qualified read-data collection: only slaves that ack contribute.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      ack_data = '0;
      ack_cnt  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         ack_data = ack_data | (s_rdata[32*i +: 32] & {32{s_ack[i]}});
         ack_cnt  = ack_cnt + 7'(s_ack[i]);
      end
      ack_any = |s_ack;
   end

   // Next-state logic of the path: request latch, wait/timeout, response.
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      addr_d        = addr_q;
      data_d        = data_q;
      s_req_d       = 1'b0;
      m_ack_d       = 1'b0;
      timeout_evt   = 1'b0;
      multi_ack_evt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m_req) begin
               state_d = ST_WAIT;
               addr_d  = m_addr;
               timer_d = '0;
               s_req_d = 1'b1;
               if (!DATA_EN) begin
                  data_d = m_wdata;
               end
            end
         end
         ST_WAIT: begin
            timer_d = timer_q + TW'(1);
            if (ack_any) begin
               // An ack in the timeout cycle still wins over the timeout.
               state_d       = ST_RESP;
               m_ack_d       = 1'b1;
               multi_ack_evt = (ack_cnt > 7'd1);
               if (DATA_EN) begin
                  data_d = ack_data;
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d     = ST_RESP;
               m_ack_d     = 1'b1;
               timeout_evt = 1'b1;
               if (DATA_EN) begin
                  data_d = TIMEOUT_RDATA;
               end
            end
         end
         ST_RESP: begin
            // Late acks here are ignored; read data returns to 0 after the pulse.
            state_d = ST_IDLE;
            if (DATA_EN) begin
               data_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; an aborted transaction emits no ack.
   // NOTE: clocked state uses non-blocking assignments so all flops update together.
   always_ff @(posedge up_clk) begin
      if (up_rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         s_req_q <= 1'b0;
         m_ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         s_req_q <= s_req_d;
         m_ack_q <= m_ack_d;
      end
   end

   assign m_ack  = m_ack_q;
   assign s_req  = s_req_q;
   assign s_addr = addr_q;
   assign data   = data_q;

endmodule

// File: rtl/ad_ip_jesd204_tpl_up_fabric.sv
// Up-bus fabric between up_axi and the TPL register slaves: independent read
// and write paths plus shared sticky error status and timeout counter.
module ad_ip_jesd204_tpl_up_fabric
   import ad_ip_jesd204_tpl_up_pkg::*;
#(
   parameter int          NUM_SLAVES     = 4,
   parameter int          ADDR_WIDTH     = 11,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
   input  logic                     up_clk,
   input  logic                     up_rst,
   input  logic                     m_wreq,
   input  logic [ADDR_WIDTH-1:0]    m_waddr,
   input  logic [31:0]              m_wdata,
   output logic                     m_wack,
   input  logic                     m_rreq,
   input  logic [ADDR_WIDTH-1:0]    m_raddr,
   output logic                     m_rack,
   output logic [31:0]              m_rdata,
   output logic                     s_wreq,
   output logic [ADDR_WIDTH-1:0]    s_waddr,
   output logic [31:0]              s_wdata,
   input  logic [NUM_SLAVES-1:0]    s_wack,
   output logic                     s_rreq,
   output logic [ADDR_WIDTH-1:0]    s_raddr,
   input  logic [NUM_SLAVES-1:0]    s_rack,
   input  logic [NUM_SLAVES*32-1:0] s_rdata,
   input  logic                     status_clr,
   output logic                     status_wr_timeout,
   output logic                     status_rd_timeout,
   output logic                     status_multi_ack,
   output logic [7:0]               status_timeout_cnt
);

   logic wr_timeout_evt, rd_timeout_evt;
   logic wr_multi_evt, rd_multi_evt;

   ad_ip_jesd204_tpl_up_txn #(
      .NUM_SLAVES     (NUM_SLAVES),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_RDATA  (TIMEOUT_RDATA),
      .DATA_EN        (1'b0)
   ) i_wr_txn (
      .up_clk        (up_clk),
      .up_rst        (up_rst),
      .m_req         (m_wreq),
      .m_addr        (m_waddr),
      .m_wdata       (m_wdata),
      .m_ack         (m_wack),
      .s_req         (s_wreq),
      .s_addr        (s_waddr),
      .s_ack         (s_wack),
      .s_rdata       (s_rdata),
      .data          (s_wdata),
      .timeout_evt   (wr_timeout_evt),
      .multi_ack_evt (wr_multi_evt)
   );

   ad_ip_jesd204_tpl_up_txn #(
      .NUM_SLAVES     (NUM_SLAVES),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_RDATA  (TIMEOUT_RDATA),
      .DATA_EN        (1'b1)
   ) i_rd_txn (
      .up_clk        (up_clk),
      .up_rst        (up_rst),
      .m_req         (m_rreq),
      .m_addr        (m_raddr),
      .m_wdata       (32'd0),
      .m_ack         (m_rack),
      .s_req         (s_rreq),
      .s_addr        (s_raddr),
      .s_ack         (s_rack),
      .s_rdata       (s_rdata),
      .data          (m_rdata),
      .timeout_evt   (rd_timeout_evt),
      .multi_ack_evt (rd_multi_evt)
   );

   logic       wr_timeout_q, wr_timeout_d;
   logic       rd_timeout_q, rd_timeout_d;
   logic       multi_ack_q, multi_ack_d;
   logic [7:0] cnt_q, cnt_d;
   logic [8:0] cnt_sum;

   // Sticky flags and saturating timeout count; a clear beats a same-cycle set.
   always_comb begin
      wr_timeout_d = wr_timeout_q | wr_timeout_evt;
      rd_timeout_d = rd_timeout_q | rd_timeout_evt;
      multi_ack_d  = multi_ack_q | wr_multi_evt | rd_multi_evt;
      cnt_sum      = {1'b0, cnt_q} + {8'd0, wr_timeout_evt} + {8'd0, rd_timeout_evt};
      cnt_d        = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
      if (status_clr) begin
         wr_timeout_d = 1'b0;
         rd_timeout_d = 1'b0;
         multi_ack_d  = 1'b0;
         cnt_d        = 8'd0;
      end
   end

   // Status registers with synchronous reset.
   always_ff @(posedge up_clk) begin
      if (up_rst) begin
         wr_timeout_q <= 1'b0;
         rd_timeout_q <= 1'b0;
         multi_ack_q  <= 1'b0;
         cnt_q        <= 8'd0;
      end else begin
         wr_timeout_q <= wr_timeout_d;
         rd_timeout_q <= rd_timeout_d;
         multi_ack_q  <= multi_ack_d;
         cnt_q        <= cnt_d;
      end
   end

   assign status_wr_timeout  = wr_timeout_q;
   assign status_rd_timeout  = rd_timeout_q;
   assign status_multi_ack   = multi_ack_q;
   assign status_timeout_cnt = cnt_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_up_fabric.sv
// Self-checking bench for the up-bus fabric: directed scenarios plus random
// transactions against a cycle-numbered transaction-level reference model.
module tb_ad_ip_jesd204_tpl_up_fabric;

   localparam int          NS    = 4;
   localparam int          AW    = 11;
   localparam int          TC    = 8;
   localparam logic [31:0] TO_RD = 32'hDEADDEAD;
   localparam int          NEVER = 99;

   logic             up_clk = 1'b0;
   logic             up_rst;
   logic             m_wreq, m_rreq;
   logic [AW-1:0]    m_waddr, m_raddr;
   logic [31:0]      m_wdata;
   logic             m_wack, m_rack;
   logic [31:0]      m_rdata;
   logic             s_wreq, s_rreq;
   logic [AW-1:0]    s_waddr, s_raddr;
   logic [31:0]      s_wdata;
   logic [NS-1:0]    s_wack, s_rack;
   logic [NS*32-1:0] s_rdata;
   logic             status_clr;
   logic             status_wr_timeout, status_rd_timeout, status_multi_ack;
   logic [7:0]       status_timeout_cnt;

   always #5 up_clk = ~up_clk;

   ad_ip_jesd204_tpl_up_fabric #(
      .NUM_SLAVES     (NS),
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TC),
      .TIMEOUT_RDATA  (TO_RD)
   ) dut (
      .up_clk             (up_clk),
      .up_rst             (up_rst),
      .m_wreq             (m_wreq),
      .m_waddr            (m_waddr),
      .m_wdata            (m_wdata),
      .m_wack             (m_wack),
      .m_rreq             (m_rreq),
      .m_raddr            (m_raddr),
      .m_rack             (m_rack),
      .m_rdata            (m_rdata),
      .s_wreq             (s_wreq),
      .s_waddr            (s_waddr),
      .s_wdata            (s_wdata),
      .s_wack             (s_wack),
      .s_rreq             (s_rreq),
      .s_raddr            (s_raddr),
      .s_rack             (s_rack),
      .s_rdata            (s_rdata),
      .status_clr         (status_clr),
      .status_wr_timeout  (status_wr_timeout),
      .status_rd_timeout  (status_rd_timeout),
      .status_multi_ack   (status_multi_ack),
      .status_timeout_cnt (status_timeout_cnt)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Reference status model.
   bit exp_wr_to, exp_rd_to, exp_multi;
   int exp_cnt;
   bit pat_mode = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge up_clk);
      #1;
   endtask

   task automatic model_clear();
      exp_wr_to = 1'b0;
      exp_rd_to = 1'b0;
      exp_multi = 1'b0;
      exp_cnt   = 0;
   endtask

   task automatic model_timeout();
      exp_cnt = (exp_cnt + 1 > 255) ? 255 : exp_cnt + 1;
   endtask

   task automatic check_status();
      check("wr_timeout", status_wr_timeout, exp_wr_to);
      check("rd_timeout", status_rd_timeout, exp_rd_to);
      check("multi_ack", status_multi_ack, exp_multi);
      check("timeout_cnt", status_timeout_cnt, exp_cnt);
   endtask

   task automatic check_all_zero();
      check("z_m_wack", m_wack, 0);
      check("z_m_rack", m_rack, 0);
      check("z_m_rdata", m_rdata, 0);
      check("z_s_wreq", s_wreq, 0);
      check("z_s_rreq", s_rreq, 0);
      check("z_s_waddr", s_waddr, 0);
      check("z_s_raddr", s_raddr, 0);
      check("z_s_wdata", s_wdata, 0);
      check_status();
   endtask

   task automatic pulse_clr();
      status_clr = 1'b1;
      tick();
      status_clr = 1'b0;
      model_clear();
      check_status();
   endtask

   // One read and/or write transaction, cycle 0 = request cycle.
   // rk/wk: cycle in which the slaves ack with rmask/wmask (a zero mask means no ack).
   task automatic run_txn(input bit do_rd, input int rk, input logic [NS-1:0] rmask,
                          input bit do_wr, input int wk, input logic [NS-1:0] wmask,
                          input bit extra_req, input bit late_ack, input int clr_at);
      logic [AW-1:0] raddr, waddr;
      logic [31:0]   wdata, exp_rd;
      bit            r_acked, w_acked;
      int            re, we, rset, wset;
      raddr   = AW'($urandom);
      waddr   = AW'($urandom);
      wdata   = $urandom;
      exp_rd  = TO_RD;
      r_acked = do_rd && rk <= TC && rmask != '0;
      w_acked = do_wr && wk <= TC && wmask != '0;
      re      = r_acked ? rk + 1 : TC + 1;
      we      = w_acked ? wk + 1 : TC + 1;
      rset    = r_acked ? rk : TC;
      wset    = w_acked ? wk : TC;

      check_status();
      m_rreq  = do_rd;
      m_raddr = raddr;
      m_wreq  = do_wr;
      m_waddr = waddr;
      m_wdata = wdata;
      tick();

      for (int c = 1; c <= TC + 5; c++) begin
         m_rreq     = extra_req && do_rd && c == 2;
         m_raddr    = (c == 2) ? ~raddr : raddr;
         m_wreq     = extra_req && do_wr && c == 2;
         m_waddr    = (c == 2) ? ~waddr : waddr;
         m_wdata    = (c == 2) ? ~wdata : wdata;
         status_clr = (c == clr_at);
         for (int i = 0; i < NS; i++) begin
            s_rdata[32*i +: 32] = pat_mode ? ((i == 2) ? 32'h1234_5678 : 32'hFFFF_FFFF) : $urandom;
         end
         s_rack = (do_rd && (c == rk || (late_ack && (c == re || c == TC + 4)))) ? rmask : '0;
         s_wack = (do_wr && (c == wk || (late_ack && (c == we || c == TC + 4)))) ? wmask : '0;
         if (r_acked && c == rk) begin
            exp_rd = 32'd0;
            for (int i = 0; i < NS; i++) begin
               if (rmask[i]) exp_rd = exp_rd | s_rdata[32*i +: 32];
            end
         end

         check_status();
         check("s_rreq", s_rreq, do_rd && c == 1);
         check("m_rack", m_rack, do_rd && c == re);
         check("m_rdata", m_rdata, (do_rd && c == re) ? exp_rd : 32'd0);
         if (do_rd && c <= re) check("s_raddr", s_raddr, raddr);
         check("s_wreq", s_wreq, do_wr && c == 1);
         check("m_wack", m_wack, do_wr && c == we);
         if (do_wr && c <= we) begin
            check("s_waddr", s_waddr, waddr);
            check("s_wdata", s_wdata, wdata);
         end

         // Status events land on the edge that closes cycle c.
         if (c == clr_at) begin
            model_clear();
         end else begin
            if (do_rd && c == rset) begin
               if (r_acked) begin
                  if ($countones(rmask) > 1) exp_multi = 1'b1;
               end else begin
                  exp_rd_to = 1'b1;
                  model_timeout();
               end
            end
            if (do_wr && c == wset) begin
               if (w_acked) begin
                  if ($countones(wmask) > 1) exp_multi = 1'b1;
               end else begin
                  exp_wr_to = 1'b1;
                  model_timeout();
               end
            end
         end
         tick();
      end
      m_rreq     = 1'b0;
      m_wreq     = 1'b0;
      s_rack     = '0;
      s_wack     = '0;
      status_clr = 1'b0;
      check_status();
   endtask

   initial begin
      bit            r_do, w_do;
      int            clr;
      up_rst     = 1'b1;
      m_wreq     = 1'b0;
      m_rreq     = 1'b0;
      m_waddr    = '0;
      m_raddr    = '0;
      m_wdata    = '0;
      s_wack     = '0;
      s_rack     = '0;
      s_rdata    = '0;
      status_clr = 1'b0;
      model_clear();
      tick();
      tick();
      check_all_zero();
      up_rst = 1'b0;

      // Standard slave: slave 2 acks at cycle 2, others drive all-ones unacked.
      pat_mode = 1'b1;
      run_txn(1, 2, 4'b0100, 0, 0, '0, 0, 0, -1);
      pat_mode = 1'b0;

      // Read timeout; late acks in RESP and at cycle 12 are ignored.
      run_txn(1, NEVER, 4'b0010, 0, 0, '0, 0, 1, -1);

      // Write with slaves 0 and 3 acking together, then clear.
      run_txn(0, 0, '0, 1, 2, 4'b1001, 0, 0, -1);
      pulse_clr();

      // Concurrent read and write timing out in the same cycle.
      run_txn(1, NEVER, '0, 1, NEVER, '0, 0, 0, -1);

      // Second request during WAIT is ignored.
      run_txn(1, 3, 4'b0001, 1, 4, 4'b0010, 1, 0, -1);

      // Clear in the timeout cycle wins over the set.
      pulse_clr();
      run_txn(1, NEVER, '0, 0, 0, '0, 0, 0, TC);

      // Combinational slaves acking in cycle 1.
      run_txn(1, 1, 4'b1000, 1, 1, 4'b0001, 0, 0, -1);

      // Ack in the timeout cycle wins: no flag, no count.
      run_txn(1, TC, 4'b0101, 1, TC, 4'b0010, 0, 0, -1);

      // Reset while a read is waiting.
      m_rreq  = 1'b1;
      m_raddr = 11'h5A5;
      tick();
      m_rreq = 1'b0;
      tick();
      tick();
      up_rst = 1'b1;
      tick();
      up_rst = 1'b0;
      model_clear();
      check_all_zero();
      for (int c = 0; c < TC + 2; c++) begin
         check("rst_m_rack", m_rack, 0);
         check("rst_m_wack", m_wack, 0);
         tick();
      end
      run_txn(1, 2, 4'b0001, 0, 0, '0, 0, 0, -1);

      // Random transactions.
      for (int n = 0; n < 40; n++) begin
         r_do = 1'($urandom_range(0, 1));
         w_do = r_do ? 1'($urandom_range(0, 1)) : 1'b1;
         clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TC + 2)) : -1;
         run_txn(r_do, int'($urandom_range(1, TC + 2)), NS'($urandom),
                 w_do, int'($urandom_range(1, TC + 2)), NS'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), clr);
      end

      // 300 timeouts in concurrent pairs: counter saturates at 255.
      pulse_clr();
      for (int n = 0; n < 150; n++) begin
         run_txn(1, NEVER, '0, 1, NEVER, '0, 0, 0, -1);
      end
      check("cnt_saturated", status_timeout_cnt, 8'd255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
